regfile_wb_arbiter: RTL and testbench
=====================================

# regfile_wb_arbiter

Write-back arbiter in front of the 32×32 register file's single write port. Up to NREQ execution units (ALU, load unit, multiplier) present write requests. The block grants one per cycle in round-robin order and drives a registered write to the register file. It also corrects read data for the write in flight, via optional read bypass.

## Interface
Parameters:
- NREQ, 3, number of write-back requesters (2..8)
- AW, 5, register address width
- DW, 32, data width

Ports:
- clk, in, 1, single clock, rising edge
- rst_n, in, 1, reset, asynchronous, active-low
- hold, in, 1, suppresses all grants while high
- req, in, NREQ, per-requester write request; level-held until acked
- req_addr, in, NREQ*AW, packed destination addresses; slice i belongs to requester i
- req_data, in, NREQ*DW, packed write data; slice i belongs to requester i
- ack, out, NREQ, one-hot grant, combinational, valid in the request cycle
- rf_we, out, 1, register-file write enable (registered)
- rf_waddr, out, AW, register-file write address (registered)
- rf_wdata, out, DW, register-file write data (registered)
- rd_addr1, in, AW, register-file read address, port 1
- rd_addr2, in, AW, register-file read address, port 2
- rf_rdata1, in, DW, raw register-file read data, port 1
- rf_rdata2, in, DW, raw register-file read data, port 2
- rdata1, out, DW, corrected read data to the datapath, port 1
- rdata2, out, DW, corrected read data to the datapath, port 2

## Operation
- Round-robin pointer ptr (range 0..NREQ-1); reset value 0.
- Grant g: the first i with req[i]=1, searching i = ptr, ptr+1, … mod NREQ.
- ack[g]=1 only when some req is high and hold=0; otherwise ack=0.
- Handshake: a requester keeps req, req_addr and req_data stable until it sees ack[i]=1 at a clock edge. At that edge the transfer completes. The requester may present a new request in the next cycle.
- On a grant, ptr ← (g+1) mod NREQ. With no grant, ptr is unchanged.
- Write stage, every edge:
  - rf_we ← grant && (req_addr[g] ≠ 0)
  - rf_waddr ← req_addr[g]
  - rf_wdata ← req_data[g]
  - With no grant: rf_we ← 0; rf_waddr and rf_wdata keep their values.
- Address 0 (hard-wired zero register): the request is acked, the pointer advances, and rf_we stays 0.
- hold=1: no ack; rf_we is 0 from the next cycle; requests stay pending; ptr is frozen.
- Simultaneous requests: exactly one ack per cycle. Any requester with req held high is granted within NREQ cycles.
- Reset asserted mid-operation: rf_we, rf_waddr, rf_wdata and ptr clear immediately. A write pending in the stage is dropped and is not retried.

## Timing
- Reset values: ack=0 (because no grant is possible in reset), rf_we=0, rf_waddr=0, rf_wdata=0, ptr=0.
- Request in cycle N gives ack in cycle N.
- rf_we is high in cycle N+1.
- The register file captures the data at the edge ending cycle N+1. Request-to-update latency is 2 edges.
- Throughput: one write per cycle, back-to-back.

## Configuration
- WB_BYPASS_EN defined:
  - rdata1 = wdata when rf_we && rd_addr1 == rf_waddr, else rf_rdata1.
  - rdata2 follows the same rule with rd_addr2 and rf_rdata2.
  - Bypass never applies to address 0, because rf_we is never set for address 0.
- WB_BYPASS_EN undefined: rdata1 = rf_rdata1 and rdata2 = rf_rdata2, pure passthrough. All ports remain present.

## Structure
- Shared package regfile_pkg holds:
  - RF_AW=5, RF_DW=32, RF_NREQ=3
  - RF_ZERO_ADDR=0
  - typedef rf_addr_t (logic [RF_AW-1:0])
  - typedef rf_data_t (logic [RF_DW-1:0])
- One sub-module, rr_arbiter: NREQ-wide round-robin grant plus pointer register, parameterised on NREQ, with ports clk, rst_n, en, req, gnt.
- The write stage and the bypass logic live in the top module.

## Test plan
- Reset: assert rst_n=0 mid-write, with rf_we=1 and waddr=7 → rf_we, rf_waddr and rf_wdata read 0 in the same cycle; after release, the first grant goes to requester 0.
- Single write: req[1]=1, addr=5, data=0xDEADBEEF in cycle N → ack[1]=1 in N; rf_we=1, rf_waddr=5, rf_wdata=0xDEADBEEF in N+1; rf_we=0 in N+2.
- Fairness: all three req held high for 6 cycles, ptr=0 at start → ack order 0,1,2,0,1,2; six consecutive rf_we=1 cycles.
- Zero register: req[2]=1 with addr=0 → ack[2]=1; rf_we stays 0; the next grant starts at requester 0.
- Hold: hold=1 for 3 cycles with req[0]=1 → ack=0 and rf_we=0 throughout; ack[0]=1 in the first cycle after hold drops.
- Bypass (WB_BYPASS_EN): rf_we=1, rf_waddr=9, rf_wdata=0x1234, rd_addr1=9, rf_rdata1=0 → rdata1=0x1234; rd_addr2=8 → rdata2=rf_rdata2. Without the macro, rdata1=0.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared register-file constants and types used by the write-back arbiter.
package regfile_pkg;

    localparam int RF_AW        = 5;
    localparam int RF_DW        = 32;
    localparam int RF_NREQ      = 3;
    localparam int RF_ZERO_ADDR = 0;

    typedef logic [RF_AW-1:0] rf_addr_t;
    typedef logic [RF_DW-1:0] rf_data_t;

endpackage

// File: rtl/regfile_wb_arbiter_rr.sv
// Round-robin arbiter: combinational one-hot grant searched from ptr upward,
// plus the pointer register that moves past each granted requester.
// ptr is exported so checkers can observe the arbitration state directly.
module rr_arbiter #(
    parameter int NREQ = 3,
    parameter int PW   = $clog2(NREQ)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            en,
    input  logic [NREQ-1:0] req,
    output logic [NREQ-1:0] gnt,
    output logic [PW-1:0]   ptr
);

    logic          found;
    logic [PW-1:0] gnt_idx;
    logic [PW-1:0] ptr_nxt;
    int unsigned   idx;

    // Pick the first requester at or after ptr, wrapping modulo NREQ.
    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        found   = 1'b0;
        idx     = 0;
        for (int k = 0; k < NREQ; k++) begin
            idx = int'(ptr) + k;
            if (idx >= NREQ) begin
                idx = idx - NREQ;
            end
            if (en && !found && req[idx]) begin
                gnt[idx] = 1'b1;
                gnt_idx  = PW'(idx);
                found    = 1'b1;
            end
        end
    end

    // Next pointer is one past the winner, wrapping at NREQ-1.
    always_comb begin
        ptr_nxt = (gnt_idx == PW'(NREQ - 1)) ? '0 : gnt_idx + 1'b1;
    end

    // Pointer only moves on a grant; frozen otherwise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr <= '0;
        end else if (found) begin
            ptr <= ptr_nxt;
        end
    end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Write-back arbiter for the register file's single write port.
// Optional read bypass of the in-flight write: define WB_BYPASS_EN.
//
// Handshake: each requester holds req[i], its req_addr and req_data slices
// stable until ack[i] is high at a rising edge; the transfer completes at
// that edge and a new request may be presented in the following cycle.
// ack is combinational and one-hot; at most one requester wins per cycle.
module regfile_wb_arbiter
    import regfile_pkg::*;
#(
    parameter int NREQ = RF_NREQ,
    parameter int AW   = RF_AW,
    parameter int DW   = RF_DW
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             hold,
    input  logic [NREQ-1:0]  req,
    input  logic [NREQ*AW-1:0] req_addr,
    input  logic [NREQ*DW-1:0] req_data,
    output logic [NREQ-1:0]  ack,
    output logic             rf_we,
    output logic [AW-1:0]    rf_waddr,
    output logic [DW-1:0]    rf_wdata,
    input  logic [AW-1:0]    rd_addr1,
    input  logic [AW-1:0]    rd_addr2,
    input  logic [DW-1:0]    rf_rdata1,
    input  logic [DW-1:0]    rf_rdata2,
    output logic [DW-1:0]    rdata1,
    output logic [DW-1:0]    rdata2
);

    localparam int PW = $clog2(NREQ);

    logic          arb_en;
    logic          grant;
    logic [AW-1:0] sel_addr;
    logic [DW-1:0] sel_data;
    logic [PW-1:0] arb_ptr;
    logic          unused_dbg;

    // No grant while held or while reset is asserted.
    assign arb_en = rst_n && !hold;

    rr_arbiter #(
        .NREQ (NREQ),
        .PW   (PW)
    ) u_arb (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (arb_en),
        .req   (req),
        .gnt   (ack),
        .ptr   (arb_ptr)
    );

    assign grant = |ack;

    // Mux the winning requester's address and data out of the packed buses.
    always_comb begin
        sel_addr = '0;
        sel_data = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (ack[i]) begin
                sel_addr = req_addr[i*AW +: AW];
                sel_data = req_data[i*DW +: DW];
            end
        end
    end

    // Registered write stage; the zero register is acked but never written.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rf_we    <= 1'b0;
            rf_waddr <= '0;
            rf_wdata <= '0;
        end else begin
            rf_we <= grant && (sel_addr != AW'(RF_ZERO_ADDR));
            if (grant) begin
                rf_waddr <= sel_addr;
                rf_wdata <= sel_data;
            end
        end
    end

`ifdef WB_BYPASS_EN
    // Forward the staged write to a read of the same address.
    always_comb begin
        rdata1 = (rf_we && (rd_addr1 == rf_waddr)) ? rf_wdata : rf_rdata1;
        rdata2 = (rf_we && (rd_addr2 == rf_waddr)) ? rf_wdata : rf_rdata2;
    end

    assign unused_dbg = ^arb_ptr;
`else
    // Plain passthrough of the register-file read data.
    always_comb begin
        rdata1 = rf_rdata1;
        rdata2 = rf_rdata2;
    end

    assign unused_dbg = ^{arb_ptr, rd_addr1, rd_addr2};
`endif

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter; expected values are hand-computed.
// Inputs change 1 ns after a rising edge, outputs are sampled 1 ns later.
module tb_regfile_wb_arbiter;

    localparam int NREQ = 3;
    localparam int AW   = 5;
    localparam int DW   = 32;

    logic             clk;
    logic             rst_n;
    logic             hold;
    logic [NREQ-1:0]  req;
    logic [NREQ*AW-1:0] req_addr;
    logic [NREQ*DW-1:0] req_data;
    logic [NREQ-1:0]  ack;
    logic             rf_we;
    logic [AW-1:0]    rf_waddr;
    logic [DW-1:0]    rf_wdata;
    logic [AW-1:0]    rd_addr1;
    logic [AW-1:0]    rd_addr2;
    logic [DW-1:0]    rf_rdata1;
    logic [DW-1:0]    rf_rdata2;
    logic [DW-1:0]    rdata1;
    logic [DW-1:0]    rdata2;

    int total = 0;
    int bad   = 0;

    regfile_wb_arbiter #(
        .NREQ (NREQ),
        .AW   (AW),
        .DW   (DW)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .hold      (hold),
        .req       (req),
        .req_addr  (req_addr),
        .req_data  (req_data),
        .ack       (ack),
        .rf_we     (rf_we),
        .rf_waddr  (rf_waddr),
        .rf_wdata  (rf_wdata),
        .rd_addr1  (rd_addr1),
        .rd_addr2  (rd_addr2),
        .rf_rdata1 (rf_rdata1),
        .rf_rdata2 (rf_rdata2),
        .rdata1    (rdata1),
        .rdata2    (rdata2)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance to 1 ns after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic [AW-1:0] a, input logic [DW-1:0] d);
        req[i] = 1'b1;
        req_addr[i*AW +: AW] = a;
        req_data[i*DW +: DW] = d;
    endtask

    initial begin
        logic [DW-1:0] exp_byp;

        rst_n = 1'b0; hold = 1'b0; req = '0; req_addr = '0; req_data = '0;
        rd_addr1 = '0; rd_addr2 = '0; rf_rdata1 = '0; rf_rdata2 = '0;

        // Reset state, with a request pending to show ack is blocked in reset
        req[0] = 1'b1;
        step();
        #1;
        check("reset_ack", ack, 3'b000);
        check("reset_we", rf_we, 1'b0);
        check("reset_waddr", rf_waddr, 5'd0);
        check("reset_wdata", rf_wdata, 32'd0);
        req = '0;
        step();
        rst_n = 1'b1;
        step();

        // Fairness: all three requesting for six cycles from ptr=0
        for (int i = 0; i < NREQ; i++) set_req(i, AW'(10 + i), DW'(32'hA0 + i));
        for (int k = 0; k < 6; k++) begin
            #1;
            check($sformatf("fair_ack%0d", k), ack, 3'b001 << (k % 3));
            if (k > 0) begin
                check($sformatf("fair_we%0d", k), rf_we, 1'b1);
                check($sformatf("fair_waddr%0d", k), rf_waddr, 10 + ((k - 1) % 3));
                check($sformatf("fair_wdata%0d", k), rf_wdata, 32'hA0 + ((k - 1) % 3));
            end
            step();
        end
        req = '0;
        #1;
        check("fair_last_we", rf_we, 1'b1);
        check("fair_last_waddr", rf_waddr, 5'd12);
        check("fair_last_ack", ack, 3'b000);
        step();

        // Single write from requester 1
        check("idle_we", rf_we, 1'b0);
        set_req(1, 5'd5, 32'hDEADBEEF);
        #1;
        check("single_ack", ack, 3'b010);
        step();
        req = '0;
        #1;
        check("single_we", rf_we, 1'b1);
        check("single_waddr", rf_waddr, 5'd5);
        check("single_wdata", rf_wdata, 32'hDEADBEEF);
        check("single_ack_drop", ack, 3'b000);
        step();
        check("single_we_n2", rf_we, 1'b0);

        // Zero register from requester 2 (ptr is 2 now)
        set_req(2, 5'd0, 32'h55);
        #1;
        check("zero_ack", ack, 3'b100);
        step();
        req = '0;
        #1;
        check("zero_we", rf_we, 1'b0);
        for (int i = 0; i < NREQ; i++) set_req(i, AW'(20 + i), DW'(i));
        #1;
        check("zero_next_ack", ack, 3'b001);
        step();
        req = '0;
        step();

        // Hold with requester 0 pending (ptr is 1)
        hold = 1'b1;
        set_req(0, 5'd3, 32'h33);
        for (int k = 0; k < 3; k++) begin
            #1;
            check($sformatf("hold_ack%0d", k), ack, 3'b000);
            check($sformatf("hold_we%0d", k), rf_we, 1'b0);
            step();
        end
        hold = 1'b0;
        #1;
        check("hold_release_ack", ack, 3'b001);
        check("hold_release_we", rf_we, 1'b0);
        step();
        #1;
        check("hold_grant_we", rf_we, 1'b1);
        check("hold_grant_waddr", rf_waddr, 5'd3);
        req = '0;
        step();

        // Bypass: stage a write to address 9
        set_req(1, 5'd9, 32'h1234);
        #1;
        check("byp_ack", ack, 3'b010);
        step();
        req = '0;
        rd_addr1 = 5'd9; rf_rdata1 = 32'h0;
        rd_addr2 = 5'd8; rf_rdata2 = 32'hAAAA5555;
        #1;
`ifdef WB_BYPASS_EN
        exp_byp = 32'h1234;
`else
        exp_byp = 32'h0;
`endif
        check("byp_rdata1", rdata1, exp_byp);
        check("byp_rdata2", rdata2, 32'hAAAA5555);
        step();
        rf_rdata1 = 32'h77;
        #1;
        check("byp_off_rdata1", rdata1, 32'h77);

        // Reset mid-write: stage address 7 from requester 0, leaving ptr at 1
        step();
        set_req(0, 5'd7, 32'hCAFE);
        #1;
        check("rst_mid_ack", ack, 3'b001);
        step();
        req = '0;
        #1;
        check("rst_mid_we_pre", rf_we, 1'b1);
        check("rst_mid_waddr_pre", rf_waddr, 5'd7);
        rst_n = 1'b0;
        #1;
        check("rst_mid_we", rf_we, 1'b0);
        check("rst_mid_waddr", rf_waddr, 5'd0);
        check("rst_mid_wdata", rf_wdata, 32'd0);
        step();
        rst_n = 1'b1;
        step();
        check("rst_mid_we_after", rf_we, 1'b0);
        for (int i = 0; i < NREQ; i++) set_req(i, AW'(1 + i), DW'(i));
        #1;
        check("rst_first_grant", ack, 3'b001);
        step();
        req = '0;
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
